reg_file_access_ctrl: RTL and testbench

// Request/response front end that initiates all accesses into reg_file_memory (port A).

---
 rtl/reg_file_pkg.sv | 13 +
 rtl/reg_file_access_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_reg_file_access_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared types for the register-file access path: access FSM encoding and default memory latency.
package reg_file_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RD_WAIT = 2'd2,
    RESP    = 2'd3
  } reg_file_acc_state_t;

  localparam int REG_FILE_RD_LATENCY_DEFAULT = 1;

endpackage

// File: rtl/reg_file_access_ctrl.sv
// Request/response front end for reg_file_memory port A: one outstanding access,
// address range check, single-cycle memory strobe, registered response channel.
module reg_file_access_ctrl
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int NUM_REGS     = 16,
  parameter int READ_LATENCY = REG_FILE_RD_LATENCY_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_WIDTH  = $clog2(READ_LATENCY + 1);
  // One extra bit so NUM_REGS == 2**ADDR_WIDTH is representable and never flags an error.
  localparam logic [ADDR_WIDTH:0] NUM_REGS_EXT = (ADDR_WIDTH + 1)'(NUM_REGS);
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD    = CNT_WIDTH'(READ_LATENCY - 1);

  if (READ_LATENCY < 1) begin : g_bad_read_latency
    $error("reg_file_access_ctrl: READ_LATENCY must be >= 1");
  end
  if ((DATA_WIDTH % 8) != 0) begin : g_bad_data_width
    $error("reg_file_access_ctrl: DATA_WIDTH must be a multiple of 8");
  end
  if (NUM_REGS > (2 ** ADDR_WIDTH)) begin : g_bad_num_regs
    $error("reg_file_access_ctrl: NUM_REGS exceeds the address space");
  end

  reg_file_acc_state_t state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [STRB_WIDTH-1:0] mem_wstrb_q, mem_wstrb_d;

  logic addr_oob;
  logic req_fire;

  assign addr_oob = ({1'b0, req_addr} >= NUM_REGS_EXT);
  assign req_fire = req_valid && req_ready_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    req_ready_d = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;

    unique case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_fire) begin
          req_ready_d = 1'b0;
          if (addr_oob) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d     = ACCESS;
            we_d        = req_we;
            mem_en_d    = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = req_addr;
            mem_wdata_d = req_wdata;
            mem_wstrb_d = req_we ? req_wstrb : '0;
          end
        end
      end

      ACCESS: begin
        if (we_q) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end else begin
          state_d = RD_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end

      // Counter hits zero in the cycle mem_rdata becomes valid.
      RD_WAIT: begin
        if (cnt_q == '0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = mem_rdata;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_reg_file_access_ctrl.sv
// Scoreboard bench for reg_file_access_ctrl with a READ_LATENCY=2 memory model on port A.
module tb_reg_file_access_ctrl;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NR = 16;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [3:0]    req_wstrb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wstrb;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  reg_file_access_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  // Memory model: two-stage read pipeline, filler data outside the valid window.
  logic [DW-1:0] mem_model [0:255];
  logic [DW-1:0] rd_s0 = '0;
  logic [DW-1:0] rd_s1 = '0;
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) mem_model[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    rd_s0 <= (mem_en && !mem_we) ? mem_model[mem_addr] : 32'h5A5A_A5A5;
    rd_s1 <= rd_s0;
  end
  assign mem_rdata = rd_s1;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    wstrb;
    logic [DW-1:0] rdata;
    logic          err;
    int            lat;
    int            hs_cycle;
    int            en_base;
    int            en_exp;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] ref_mem [0:255];
  int            n_cmp = 0;
  int            n_mis = 0;
  int            cycle_cnt = 0;
  int            mem_en_total = 0;
  logic          rsp_valid_prev = 1'b0;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Response monitor: latency on rsp_valid rise, memory strobe contents, popped results.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      rsp_valid_prev <= 1'b0;
    end else begin
      rsp_valid_prev <= rsp_valid;
      if (mem_en) begin
        mem_en_total <= mem_en_total + 1;
        if (exp_q.size() > 0) begin
          check_val("mem_we", {31'd0, mem_we}, {31'd0, exp_q[0].we});
          check_val("mem_addr", {24'd0, mem_addr}, {24'd0, exp_q[0].addr});
          check_val("mem_wstrb", {28'd0, mem_wstrb}, exp_q[0].we ? {28'd0, exp_q[0].wstrb} : 32'd0);
          if (exp_q[0].we) check_val("mem_wdata", mem_wdata, exp_q[0].wdata);
        end
      end
      if (rsp_valid && !rsp_valid_prev && exp_q.size() > 0)
        check_val("rsp_latency", 32'(cycle_cnt - exp_q[0].hs_cycle), 32'(exp_q[0].lat));
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check_val("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          check_val("rsp_rdata", rsp_rdata, exp_q[0].rdata);
          check_val("rsp_err", {31'd0, rsp_err}, {31'd0, exp_q[0].err});
          check_val("mem_en_count", 32'(mem_en_total - exp_q[0].en_base), 32'(exp_q[0].en_exp));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic do_req(input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [3:0] wstrb);
    exp_t e;
    int   t;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = wstrb;
    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      check_val("req_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    e.we       = we;
    e.addr     = addr;
    e.wdata    = wdata;
    e.wstrb    = wstrb;
    e.err      = (addr >= AW'(NR));
    e.rdata    = (e.err || we) ? '0 : ref_mem[addr];
    e.lat      = e.err ? 1 : (we ? 2 : 2 + RL);
    e.hs_cycle = cycle_cnt;
    e.en_base  = mem_en_total;
    e.en_exp   = e.err ? 0 : 1;
    if (we && !e.err)
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) ref_mem[addr][8*b +: 8] = wdata[8*b +: 8];
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) check_val("rsp_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_req_ready"}, {31'd0, req_ready}, 32'd0);
    check_val({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check_val({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
    check_val({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check_val({tag, "_mem_en"}, {31'd0, mem_en}, 32'd0);
    check_val({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    check_val({tag, "_mem_addr"}, {24'd0, mem_addr}, 32'd0);
    check_val({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check_val({tag, "_mem_wstrb"}, {28'd0, mem_wstrb}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] m20;
    int            t;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    #1;
    check_val("ready_at_release", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check_val("ready_after_release", {31'd0, req_ready}, 32'd1);

    // 1/2: write then read back
    do_req(1'b1, 8'd3, 32'hDEAD_BEEF, 4'hF);
    wait_rsp();
    do_req(1'b0, 8'd3, 32'h0, 4'h0);
    wait_rsp();

    // 3: out-of-range write, no memory access
    m20 = mem_model[20];
    do_req(1'b1, 8'd20, 32'h1234_5678, 4'hF);
    wait_rsp();
    check_val("oob_mem_untouched", mem_model[20], m20);

    // 4: stalled response, second request must not be accepted
    rsp_ready = 1'b0;
    do_req(1'b0, 8'd3, 32'h0, 4'h0);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 8'd7;
    req_wdata = 32'h0000_0055;
    req_wstrb = 4'hF;
    t = 0;
    while (!rsp_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check_val("stall_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
      check_val("stall_req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_rsp();
    repeat (4) @(negedge clk);

    // 5: partial byte write
    do_req(1'b1, 8'd5, 32'hFFFF_FFFF, 4'hF);
    wait_rsp();
    do_req(1'b1, 8'd5, 32'h1122_3344, 4'h3);
    wait_rsp();
    do_req(1'b0, 8'd5, 32'h0, 4'h0);
    wait_rsp();
    check_val("partial_write_mem", mem_model[5], 32'hFFFF_3344);

    // 6: reset during RD_WAIT drops the read
    do_req(1'b0, 8'd3, 32'h0, 4'h0);
    @(posedge clk);
    #1;
    check_val("rdwait_mem_addr", {24'd0, mem_addr}, 32'd3);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check_val("no_rsp_after_reset", {31'd0, rsp_valid}, 32'd0);
    do_req(1'b0, 8'd5, 32'h0, 4'h0);
    wait_rsp();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
